// File: rtl/systolic_pkg.sv
// Shared defaults, FSM encoding and element type for the systolic array edge feeder.
package systolic_pkg;

    localparam int N_DEFAULT  = 16;
    localparam int DW_DEFAULT = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    typedef logic [DW_DEFAULT-1:0] elem_t;

    // Beat counter width: must cover RUN (2N-1 beats) and FLUSH (N beats) without wrapping.
    function automatic int kw(input int n);
        return $clog2(3 * n);
    endfunction

endpackage

// File: rtl/systolic_operand_buf.sv
// N x N operand store written one line per cycle; read port returns the diagonal skew for beat k.
module systolic_operand_buf
    import systolic_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int DW = DW_DEFAULT,
    parameter int KW = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [$clog2(N)-1:0]  wr_idx,
    input  logic [N*DW-1:0]       wr_data,
    input  logic [KW-1:0]         k,
    output logic [N*DW-1:0]       skew
);

    localparam int IW = $clog2(N);

    // Line i holds A row i (or B column i); element m sits at [m*DW +: DW].
    logic [N*DW-1:0] mem [N];
    logic [N*DW-1:0] line;
    logic [DW-1:0]   row_e [N];
    logic [KW-1:0]   d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // A write in the same cycle is forwarded so a start alongside a load streams the new line.
    always_comb begin
        skew = '0;
        line = '0;
        d    = '0;
        for (int m = 0; m < N; m++) begin
            row_e[m] = '0;
        end
        for (int i = 0; i < N; i++) begin
            d    = k - KW'(i);
            line = (wr_en && wr_idx == IW'(i)) ? wr_data : mem[i];
            for (int m = 0; m < N; m++) begin
                row_e[m] = line[m*DW +: DW];
            end
            if (k >= KW'(i) && d < KW'(N)) begin
                skew[i*DW +: DW] = row_e[d[IW-1:0]];
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Streams skewed A rows / B columns into the edges of an N x N systolic array.
// Define SYSTOLIC_FEEDER_FLUSH_EN to append N zero beats that drain the partial sums.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic                  ld_sel,
    input  logic [$clog2(N)-1:0]  ld_idx,
    input  logic [N*DW-1:0]       ld_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [N*DW-1:0]       a_edge,
    output logic [N*DW-1:0]       b_edge,
    output logic                  edge_valid,
    output state_t                fsm_state
);

    localparam int KW = kw(N);
    localparam logic [KW-1:0] LAST_K = KW'(2 * N - 2);
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
    localparam logic [KW-1:0] FLUSH_END = KW'(3 * N - 2);
`endif

    // Handshake: a load word transfers on any rising edge where ld_valid && ld_ready.
    state_t          state;
    logic [KW-1:0]   k;
    logic [KW-1:0]   rd_k;
    logic [N*DW-1:0] a_skew;
    logic [N*DW-1:0] b_skew;
    logic            ld_fire;

    assign ld_ready  = (state == ST_IDLE);
    assign ld_fire   = ld_valid && ld_ready;
    assign busy      = (state == ST_RUN) || (state == ST_FLUSH);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

    // k names the beat on the edge registers now, so the read port looks one beat ahead.
    assign rd_k = (state == ST_RUN) ? k + KW'(1) : '0;

    systolic_operand_buf #(.N(N), .DW(DW), .KW(KW)) u_a_buf (
        .clk     (clk),
        .wr_en   (ld_fire && !ld_sel),
        .wr_idx  (ld_idx),
        .wr_data (ld_data),
        .k       (rd_k),
        .skew    (a_skew)
    );

    systolic_operand_buf #(.N(N), .DW(DW), .KW(KW)) u_b_buf (
        .clk     (clk),
        .wr_en   (ld_fire && ld_sel),
        .wr_idx  (ld_idx),
        .wr_data (ld_data),
        .k       (rd_k),
        .skew    (b_skew)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            k          <= '0;
            a_edge     <= '0;
            b_edge     <= '0;
            edge_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        k          <= '0;
                        a_edge     <= a_skew;
                        b_edge     <= b_skew;
                        edge_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (k == LAST_K) begin
                        a_edge <= '0;
                        b_edge <= '0;
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
                        state      <= ST_FLUSH;
                        k          <= k + KW'(1);
                        edge_valid <= 1'b1;
`else
                        state      <= ST_DONE;
                        k          <= '0;
                        edge_valid <= 1'b0;
`endif
                    end else begin
                        k      <= k + KW'(1);
                        a_edge <= a_skew;
                        b_edge <= b_skew;
                    end
                end
                ST_FLUSH: begin
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
                    if (k == FLUSH_END) begin
                        state      <= ST_DONE;
                        k          <= '0;
                        edge_valid <= 1'b0;
                    end else begin
                        k <= k + KW'(1);
                    end
`else
                    state      <= ST_IDLE;
                    k          <= '0;
                    edge_valid <= 1'b0;
`endif
                end
                default: begin
                    state      <= ST_IDLE;
                    k          <= '0;
                    a_edge     <= '0;
                    b_edge     <= '0;
                    edge_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the systolic array dimension (rows = columns).
REQ-002 The block SHALL have parameter DW, default 8, giving the operand width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port ld_valid, input, 1 bit, indicating that a load word is offered.
REQ-006 The block SHALL have port ld_ready, output, 1 bit, indicating that a load word can be accepted.
REQ-007 The block SHALL have port ld_sel, input, 1 bit, selecting the load target: 0 = A row, 1 = B column.
REQ-008 The block SHALL have port ld_idx, input, $clog2(N) bits, giving the row index (A) or column index (B).
REQ-009 The block SHALL have port ld_data, input, N*DW bits: element m at [m*DW +: DW] is A[idx][m] when ld_sel=0 and B[m][idx] when ld_sel=1.
REQ-010 The block SHALL have port start, input, 1 bit, a request to begin streaming.
REQ-011 The block SHALL have port busy, output, 1 bit, high while streaming.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-013 The block SHALL have port a_edge, output, N*DW bits: slice i drives the a input of array row i, column 0.
REQ-014 The block SHALL have port b_edge, output, N*DW bits: slice j drives the b input of array row 0, column j.
REQ-015 The block SHALL have port edge_valid, output, 1 bit, high on every cycle the edge buses carry a stream beat.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, FLUSH and DONE.
REQ-017 ld_ready SHALL be high only in IDLE.
REQ-018 On a cycle with ld_valid & ld_ready, ld_data SHALL be written to the selected A row or B column; loads in other states SHALL be ignored.
REQ-019 start SHALL be accepted only in IDLE and SHALL move the FSM to RUN with beat counter k=0; start outside IDLE SHALL be ignored.
REQ-020 If a load and an accepted start occur in the same cycle, the load SHALL complete and the stream SHALL use the updated buffer.
REQ-021 In RUN, beat k SHALL drive a_edge[i] = A[i][k-i] and b_edge[j] = B[k-j][j] when 0 <= k-i or k-j <= N-1, and 0 otherwise.
REQ-022 RUN SHALL last exactly 2N-1 cycles (k = 0..2N-2), with edge_valid=1 and busy=1 throughout.
REQ-023 The first beat SHALL appear on the cycle after start is accepted, with no gaps between beats.
REQ-024 k SHALL be at least $clog2(3N) bits wide and SHALL not wrap during a run.
REQ-025 After the last RUN beat, the FSM SHALL go to FLUSH if enabled (REQ-031), else to DONE.
REQ-026 DONE SHALL last one cycle with done=1, busy=0 and edge buses 0, then return to IDLE.
REQ-027 Outside RUN/FLUSH, a_edge, b_edge and edge_valid SHALL be 0.
REQ-028 Edge outputs SHALL be registered.

Reset
REQ-029 While rst=0, the FSM SHALL be in IDLE with k=0, and busy, done, edge_valid, a_edge and b_edge SHALL be 0; ld_ready SHALL be 1 after release.
REQ-030 Reset asserted mid-run SHALL abort immediately without a done pulse; buffer contents are not reset and are undefined after reset.

Configuration
REQ-031 With SYSTOLIC_FEEDER_FLUSH_EN defined, FLUSH SHALL last N cycles driving zero edge buses with edge_valid=1 and busy=1, so that partial sums drain; without the macro, FLUSH is never entered and RUN goes directly to DONE.

Structure
REQ-032 Package systolic_pkg SHALL hold N and DW defaults, the FSM state typedef and the operand element typedef.
REQ-033 The A and B storage SHALL be one sub-module, systolic_operand_buf, instanced twice, with one row/column write port and a combinational skew read port indexed by k.

Verification
REQ-034 Load A=I (identity) and B[r][c]=r*16+c, then start: beat 0 gives a_edge[0]=1, b_edge[0]=0, others 0; beat 17 gives b_edge[1]=B[16][1]... (out of range, so 0), and b_edge[2]=B[15][2]=242; exactly 31 beats occur, then done.
REQ-035 Assert start and ld_valid (ld_sel=0, idx=0, all elements 5) in the same cycle: ld accepted, and beat 0 gives a_edge[0]=5.
REQ-036 Assert start and ld_valid during RUN: both ignored, ld_ready=0, stream unchanged, single done.
REQ-037 Assert rst=0 at beat 10: all outputs 0 asynchronously, no done; after release, ld_ready=1 and a new start streams 31 beats.
REQ-038 With SYSTOLIC_FEEDER_FLUSH_EN: 31 data beats plus 16 zero beats, busy=1 for 47 cycles, done on cycle 48 after start; without the macro, done on cycle 32.
